pl_preload_ctl: RTL and testbench

Initiator for the BRAM preload bus (PL_ENA/PL_WEN/PL_REN/PL_INIT/PL_ADDR/PL_DATA) that the TDP18K_FIFO RAM tiles respond to. The block takes block-transfer commands from the configuration/debug fabric and turns them into preload bus cycles:
- WRITE: burst writes to one RAM.
- READ: burst read-back from one RAM.
- FILL: broadcast fill of all RAMs.

It sits once per preload chain, between the config controller and the chain head. Read data is returned through a credit-limited output FIFO.

---
 rtl/pl_preload_pkg.sv | 42 ++++
 rtl/pl_rd_fifo.sv | 46 ++++
 rtl/pl_preload_ctl.sv | 225 ++++++++++++++++++++++
 tb/tb_pl_preload_ctl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pl_preload_pkg.sv
// Shared types and field layout for the BRAM preload bus initiator.
// PL_ADDR carries {column, row, 2'b00, word}; opcodes match CMD_OP_i encoding.
package pl_preload_pkg;

    localparam int unsigned IdW     = 20;
    localparam int unsigned AddrW   = 10;
    localparam int unsigned DataW   = 18;
    localparam int unsigned PlAddrW = 32;

    localparam int unsigned ColMsb  = 31;
    localparam int unsigned ColLsb  = 22;
    localparam int unsigned RowMsb  = 21;
    localparam int unsigned RowLsb  = 12;
    localparam int unsigned WordMsb = 9;
    localparam int unsigned WordLsb = 0;

    typedef enum logic [1:0] {
        OpWrite = 2'b00,
        OpRead  = 2'b01,
        OpFill  = 2'b10,
        OpRsvd  = 2'b11
    } pl_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StXfer,
        StDrain,
        StTeardown
    } pl_state_e;

    function automatic logic [PlAddrW-1:0] pl_addr(input logic [IdW-1:0]   id,
                                                   input logic [AddrW-1:0] word);
        logic [PlAddrW-1:0] a;
        a                  = '0;
        a[ColMsb:ColLsb]   = id[19:10];
        a[RowMsb:RowLsb]   = id[9:0];
        a[WordMsb:WordLsb] = word;
        return a;
    endfunction

endpackage

// File: rtl/pl_rd_fifo.sv
// Synchronous FIFO for read-return data; count_o feeds the read-credit check.
// Depth must be a power of two so the pointers wrap naturally.
module pl_rd_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 18
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [Width-1:0]         data_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q;
    logic             pop;

    assign valid_o = (count_q != '0);
    assign pop     = valid_o & ready_i;
    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + PtrW'(1);
            if (pop)    rptr_q <= rptr_q + PtrW'(1);
            count_q <= count_q + CntW'(push_i) - CntW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/pl_preload_ctl.sv
// Preload bus initiator: turns WRITE/READ/FILL block commands into PL_* bus cycles.
// PL_* outputs are registered from the current state, so they trail state_q by one cycle.
module pl_preload_ctl
    import pl_preload_pkg::*;
#(
    parameter int unsigned RD_LAT        = 1,
    parameter int unsigned RD_FIFO_DEPTH = 4
) (
    input  logic               CLK_i,
    input  logic               RESET_ni,
    input  logic               CMD_VALID_i,
    output logic               CMD_READY_o,
    input  logic [1:0]         CMD_OP_i,
    input  logic [IdW-1:0]     CMD_ID_i,
    input  logic [AddrW-1:0]   CMD_ADDR_i,
    input  logic [AddrW-1:0]   CMD_LEN_i,
    input  logic               WD_VALID_i,
    output logic               WD_READY_o,
    input  logic [DataW-1:0]   WD_DATA_i,
    output logic               RD_VALID_o,
    input  logic               RD_READY_i,
    output logic [DataW-1:0]   RD_DATA_o,
    output logic               PL_ENA_o,
    output logic               PL_INIT_o,
    output logic               PL_WEN_o,
    output logic               PL_REN_o,
    output logic [PlAddrW-1:0] PL_ADDR_o,
    output logic [DataW-1:0]   PL_DATA_o,
    input  logic [DataW-1:0]   PL_DATA_RD_i,
    output logic               BUSY_o,
    output logic               DONE_o,
    output logic               ERR_o
);

    localparam int unsigned CntW = $clog2(RD_FIFO_DEPTH) + 1;

    pl_state_e          state_q, state_d;
    pl_op_e             op_q, op_d, cmd_op;
    logic [IdW-1:0]     id_q, id_d;
    logic [AddrW-1:0]   addr_q, addr_d;
    logic [10:0]        rem_q, rem_d;
    logic [DataW-1:0]   fill_word_q, fill_word_d, wr_word;
    logic               fill_have_q, fill_have_d;
    logic               pl_ena_q, pl_ena_d, pl_init_q, pl_init_d;
    logic               pl_wen_q, pl_wen_d, pl_ren_q, pl_ren_d;
    logic [PlAddrW-1:0] pl_addr_q, pl_addr_d;
    logic [DataW-1:0]   pl_data_q, pl_data_d;
    logic               cmd_rdy_q, busy_q, busy_d, done_q, done_d, err_q;
    logic [RD_LAT-1:0]  rd_pipe_q, rd_pipe_d;
    logic [CntW-1:0]    inflight_q, inflight_d, fifo_cnt;
    logic [CntW:0]      credit_used;
    logic               accept, illegal, cmd_take, is_fill, last;
    logic               wr_strobe, rd_strobe, credit_ok, fifo_push;

    assign cmd_op   = pl_op_e'(CMD_OP_i);
    assign accept   = CMD_VALID_i & cmd_rdy_q & (state_q == StIdle);
    // A read must address exactly one RAM; zero column or row would be a wildcard.
    assign illegal  = (cmd_op == OpRsvd) ||
                      ((cmd_op == OpRead) && ((CMD_ID_i[19:10] == '0) || (CMD_ID_i[9:0] == '0)));
    assign cmd_take = accept & ~illegal;
    assign is_fill  = (op_q == OpFill);
    assign last     = (rem_q == 11'd1);

    assign WD_READY_o = (state_q == StXfer) &&
                        ((op_q == OpWrite) || (is_fill && !fill_have_q));
    assign wr_strobe  = (state_q == StXfer) &&
                        (((op_q == OpWrite) && WD_VALID_i) ||
                         (is_fill && (fill_have_q || WD_VALID_i)));
    assign wr_word    = (is_fill && fill_have_q) ? fill_word_q : WD_DATA_i;

    assign credit_used = {1'b0, fifo_cnt} + {1'b0, inflight_q};
    assign credit_ok   = credit_used < (CntW + 1)'(RD_FIFO_DEPTH);
    assign rd_strobe   = (state_q == StXfer) && (op_q == OpRead) && credit_ok;
    assign fifo_push   = rd_pipe_q[RD_LAT-1];

    always_ff @(posedge CLK_i) begin
        if (!RESET_ni) state_q <= StIdle;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (cmd_take) state_d = StSetup;
            StSetup:    state_d = StXfer;
            StXfer:     if ((wr_strobe || rd_strobe) && last)
                            state_d = (op_q == OpRead) ? StDrain : StTeardown;
            StDrain:    if (inflight_q == '0) state_d = StTeardown;
            StTeardown: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        pl_ena_d    = 1'b0;
        pl_init_d   = 1'b0;
        pl_wen_d    = 1'b0;
        pl_ren_d    = 1'b0;
        pl_addr_d   = pl_addr_q;
        pl_data_d   = pl_data_q;
        op_d        = op_q;
        id_d        = id_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        fill_word_d = fill_word_q;
        fill_have_d = fill_have_q;
        unique case (state_q)
            StIdle: begin
                pl_addr_d = '0;
                pl_data_d = '0;
                if (cmd_take) begin
                    op_d        = cmd_op;
                    id_d        = CMD_ID_i;
                    addr_d      = CMD_ADDR_i;
                    rem_d       = 11'(CMD_LEN_i) + 11'd1;
                    fill_have_d = 1'b0;
                end
            end
            StSetup: begin
                pl_ena_d  = 1'b1;
                pl_init_d = is_fill;
                pl_addr_d = pl_addr(id_q, addr_q);
            end
            StXfer: begin
                pl_ena_d  = 1'b1;
                pl_init_d = is_fill;
                if (wr_strobe || rd_strobe) begin
                    pl_wen_d  = wr_strobe;
                    pl_ren_d  = rd_strobe;
                    pl_addr_d = pl_addr(id_q, addr_q);
                    addr_d    = addr_q + AddrW'(1);
                    rem_d     = rem_q - 11'd1;
                end
                if (wr_strobe) pl_data_d = wr_word;
                if (wr_strobe && is_fill && !fill_have_q) begin
                    fill_word_d = WD_DATA_i;
                    fill_have_d = 1'b1;
                end
            end
            StDrain, StTeardown: begin
                pl_ena_d  = 1'b1;
                pl_init_d = is_fill;
            end
            default: ;
        endcase

        rd_pipe_d    = rd_pipe_q << 1;
        rd_pipe_d[0] = pl_ren_q;
        inflight_d   = inflight_q + CntW'(rd_strobe) - CntW'(fifo_push);

        // Completion is flagged when the registered enable actually falls.
        done_d = pl_ena_q & ~pl_ena_d;
        busy_d = busy_q;
        if (done_d)   busy_d = 1'b0;
        if (cmd_take) busy_d = 1'b1;
    end

    always_ff @(posedge CLK_i) begin
        if (!RESET_ni) begin
            op_q        <= OpWrite;
            id_q        <= '0;
            addr_q      <= '0;
            rem_q       <= '0;
            fill_word_q <= '0;
            fill_have_q <= 1'b0;
            pl_ena_q    <= 1'b0;
            pl_init_q   <= 1'b0;
            pl_wen_q    <= 1'b0;
            pl_ren_q    <= 1'b0;
            pl_addr_q   <= '0;
            pl_data_q   <= '0;
            cmd_rdy_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_pipe_q   <= '0;
            inflight_q  <= '0;
        end else begin
            op_q        <= op_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            fill_word_q <= fill_word_d;
            fill_have_q <= fill_have_d;
            pl_ena_q    <= pl_ena_d;
            pl_init_q   <= pl_init_d;
            pl_wen_q    <= pl_wen_d;
            pl_ren_q    <= pl_ren_d;
            pl_addr_q   <= pl_addr_d;
            pl_data_q   <= pl_data_d;
            cmd_rdy_q   <= (state_d == StIdle);
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= accept & illegal;
            rd_pipe_q   <= rd_pipe_d;
            inflight_q  <= inflight_d;
        end
    end

    pl_rd_fifo #(
        .Depth (RD_FIFO_DEPTH),
        .Width (DataW)
    ) u_rd_fifo (
        .clk_i   (CLK_i),
        .rst_ni  (RESET_ni),
        .push_i  (fifo_push),
        .data_i  (PL_DATA_RD_i),
        .valid_o (RD_VALID_o),
        .ready_i (RD_READY_i),
        .data_o  (RD_DATA_o),
        .count_o (fifo_cnt)
    );

    assign CMD_READY_o = cmd_rdy_q;
    assign PL_ENA_o    = pl_ena_q;
    assign PL_INIT_o   = pl_init_q;
    assign PL_WEN_o    = pl_wen_q;
    assign PL_REN_o    = pl_ren_q;
    assign PL_ADDR_o   = pl_addr_q;
    assign PL_DATA_o   = pl_data_q;
    assign BUSY_o      = busy_q;
    assign DONE_o      = done_q;
    assign ERR_o       = err_q;

endmodule

// File: tb/tb_pl_preload_ctl.sv
// Bench for pl_preload_ctl: command table, randomized commands against a transaction-level
// model of expected bus traffic and read returns, plus reset-during-read sequence.
module tb_pl_preload_ctl;

    localparam int RdLat = 2;
    localparam int Depth = 4;

    logic        clk = 1'b0;
    logic        RESET_ni = 1'b0;
    logic        CMD_VALID_i = 1'b0, CMD_READY_o;
    logic [1:0]  CMD_OP_i = '0;
    logic [19:0] CMD_ID_i = '0;
    logic [9:0]  CMD_ADDR_i = '0, CMD_LEN_i = '0;
    logic        WD_VALID_i = 1'b0, WD_READY_o;
    logic [17:0] WD_DATA_i = '0;
    logic        RD_VALID_o, RD_READY_i = 1'b0;
    logic [17:0] RD_DATA_o;
    logic        PL_ENA_o, PL_INIT_o, PL_WEN_o, PL_REN_o;
    logic [31:0] PL_ADDR_o;
    logic [17:0] PL_DATA_o, PL_DATA_RD_i;
    logic        BUSY_o, DONE_o, ERR_o;

    always #5 clk = ~clk;

    pl_preload_ctl #(
        .RD_LAT        (RdLat),
        .RD_FIFO_DEPTH (Depth)
    ) dut (
        .CLK_i        (clk),
        .RESET_ni     (RESET_ni),
        .CMD_VALID_i  (CMD_VALID_i),
        .CMD_READY_o  (CMD_READY_o),
        .CMD_OP_i     (CMD_OP_i),
        .CMD_ID_i     (CMD_ID_i),
        .CMD_ADDR_i   (CMD_ADDR_i),
        .CMD_LEN_i    (CMD_LEN_i),
        .WD_VALID_i   (WD_VALID_i),
        .WD_READY_o   (WD_READY_o),
        .WD_DATA_i    (WD_DATA_i),
        .RD_VALID_o   (RD_VALID_o),
        .RD_READY_i   (RD_READY_i),
        .RD_DATA_o    (RD_DATA_o),
        .PL_ENA_o     (PL_ENA_o),
        .PL_INIT_o    (PL_INIT_o),
        .PL_WEN_o     (PL_WEN_o),
        .PL_REN_o     (PL_REN_o),
        .PL_ADDR_o    (PL_ADDR_o),
        .PL_DATA_o    (PL_DATA_o),
        .PL_DATA_RD_i (PL_DATA_RD_i),
        .BUSY_o       (BUSY_o),
        .DONE_o       (DONE_o),
        .ERR_o        (ERR_o)
    );

    function automatic logic [31:0] bus_addr(input logic [19:0] id, input logic [9:0] w);
        return {id, 2'b00, w};
    endfunction

    // Content the RAM chain returns for a given preload address.
    function automatic logic [17:0] chain_word(input logic [31:0] a);
        return a[17:0] ^ {a[31:22], a[21:14]} ^ 18'h1B3C5;
    endfunction

    // Chain tail: data for a PL_REN_o cycle shows up RdLat cycles later.
    logic        dl_v [RdLat] = '{default: 1'b0};
    logic [31:0] dl_a [RdLat] = '{default: 32'h0};
    always @(posedge clk) begin
        dl_v[0] <= PL_REN_o;
        dl_a[0] <= PL_ADDR_o;
        for (int i = 1; i < RdLat; i++) begin
            dl_v[i] <= dl_v[i-1];
            dl_a[i] <= dl_a[i-1];
        end
    end
    assign PL_DATA_RD_i = dl_v[RdLat-1] ? chain_word(dl_a[RdLat-1]) : 18'h2DEAD;

    // Bus monitor, sampled on the falling edge.
    logic [31:0] wq_a[$], rq_a[$];
    logic [17:0] wq_d[$], rd_q[$];
    int          ena_cnt, ena_rise, init_cnt, done_cnt, err_cnt, wd_hs, hold_bad, done_bad;
    logic        ena_prev = 1'b0;
    logic [31:0] last_addr, first_addr;

    task automatic mon_clear();
        wq_a.delete(); wq_d.delete(); rq_a.delete(); rd_q.delete();
        ena_cnt = 0; ena_rise = 0; init_cnt = 0; done_cnt = 0; err_cnt = 0;
        wd_hs = 0; hold_bad = 0; done_bad = 0;
    endtask

    always @(negedge clk) begin
        if (PL_ENA_o) begin
            ena_cnt++;
            if (PL_INIT_o) init_cnt++;
            if (!ena_prev) begin
                ena_rise++;
                first_addr = PL_ADDR_o;
                last_addr  = PL_ADDR_o;
            end else if (PL_WEN_o || PL_REN_o) begin
                last_addr = PL_ADDR_o;
            end else if (PL_ADDR_o != last_addr) begin
                hold_bad++;
            end
        end else if (PL_WEN_o || PL_REN_o) begin
            hold_bad++;
        end
        if (PL_WEN_o) begin wq_a.push_back(PL_ADDR_o); wq_d.push_back(PL_DATA_o); end
        if (PL_REN_o) rq_a.push_back(PL_ADDR_o);
        if (DONE_o) begin
            done_cnt++;
            if (PL_ENA_o || !ena_prev) done_bad++;
        end
        if (ERR_o) err_cnt++;
        if (WD_VALID_i && WD_READY_o) wd_hs++;
        if (RD_VALID_o && RD_READY_i) rd_q.push_back(RD_DATA_o);
        ena_prev = PL_ENA_o;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [17:0] words [1024];

    task automatic run_cmd(input logic [1:0] op, input logic [19:0] id, input logic [9:0] addr,
                           input logic [9:0] len, input int wd_pct, input int rd_pct,
                           input int gap, input int hold, input int fw, input int exp_ena);
        int n, need, widx, cyc, gapcnt, bad;
        bit illegal, hs, done;
        logic [9:0] w;
        n       = int'(len) + 1;
        illegal = (op == 2'b11) || (op == 2'b01 && (id[19:10] == '0 || id[9:0] == '0));
        need    = (op == 2'b00) ? n : (op == 2'b10) ? 1 : 0;
        for (int k = 0; k < n; k++) words[k] = 18'($urandom);
        if (fw >= 0) words[0] = 18'(fw);
        mon_clear();
        CMD_VALID_i = 1'b1; CMD_OP_i = op; CMD_ID_i = id; CMD_ADDR_i = addr; CMD_LEN_i = len;
        cyc = 0;
        while (!CMD_READY_o && cyc < 50) begin step(); cyc++; end
        chk("cmd_accept_timeout", longint'(cyc >= 50), 0);
        step();
        CMD_VALID_i = 1'b0;
        if (illegal) begin
            chk("err_pulse", ERR_o, 1);
            chk("err_cmd_ready", CMD_READY_o, 1);
            repeat (4) step();
            chk("err_count", err_cnt, 1);
            chk("err_no_ena", ena_cnt, 0);
            chk("err_no_done", done_cnt + int'(BUSY_o), 0);
            return;
        end
        chk("busy_after_accept", BUSY_o, 1);
        widx = 0; cyc = 0; gapcnt = 0; done = 1'b0;
        while (!done && cyc < 5000) begin
            if (cyc == hold && hold > 0)
                chk("ren_stall_count", rq_a.size(), (n < Depth) ? n : Depth);
            WD_DATA_i  = words[widx < n ? widx : 0];
            WD_VALID_i = (widx < need) && (gapcnt == 0) && (int'($urandom_range(99)) < wd_pct);
            RD_READY_i = (cyc >= hold) && (int'($urandom_range(99)) < rd_pct);
            hs = WD_VALID_i && WD_READY_o;
            step();
            cyc++;
            if (hs) begin
                widx++;
                if (widx == 1) gapcnt = gap;
            end else if (gapcnt > 0) begin
                gapcnt--;
            end
            done = DONE_o;
        end
        WD_VALID_i = 1'b0;
        chk("done_timeout", longint'(!done), 0);
        chk("busy_at_done", BUSY_o, 0);
        RD_READY_i = 1'b1;
        cyc = 0;
        while (RD_VALID_o && cyc < 50) begin step(); cyc++; end
        RD_READY_i = 1'b0;
        repeat (2) step();
        chk("done_count", done_cnt, 1);
        chk("done_timing", done_bad, 0);
        chk("ena_single_burst", ena_rise, 1);
        chk("addr_hold", hold_bad, 0);
        chk("setup_addr", first_addr, bus_addr(id, addr));
        chk("init_cycles", init_cnt, (op == 2'b10) ? ena_cnt : 0);
        if (exp_ena >= 0) chk("ena_cycles", ena_cnt, exp_ena);
        bad = 0;
        if (op == 2'b01) begin
            chk("wen_count", wq_a.size(), 0);
            chk("ren_count", rq_a.size(), n);
            chk("rd_return_count", rd_q.size(), n);
            for (int k = 0; k < n; k++) begin
                w = addr + 10'(k);
                if (k < rq_a.size() && rq_a[k] !== bus_addr(id, w)) bad++;
                if (k < rd_q.size() && rd_q[k] !== chain_word(bus_addr(id, w))) bad++;
            end
            chk("rd_mismatches", bad, 0);
        end else begin
            chk("ren_count", rq_a.size(), 0);
            chk("wen_count", wq_a.size(), n);
            chk("wd_handshakes", wd_hs, need);
            for (int k = 0; k < n; k++) begin
                w = addr + 10'(k);
                if (k < wq_a.size() && (wq_a[k] !== bus_addr(id, w) ||
                    wq_d[k] !== words[(op == 2'b10) ? 0 : k])) bad++;
            end
            chk("wr_mismatches", bad, 0);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [19:0] id;
        logic [9:0]  addr;
        logic [9:0]  len;
        int          wd_pct, rd_pct, gap, hold, fw, exp_ena;
    } vec_t;

    vec_t vecs[11];
    int   cyc;
    int   seen;

    initial begin
        vecs[0]  = '{2'b00, 20'h00401, 10'h3FE, 10'd3,    100, 100, 0, 0,  -1, 6};
        vecs[1]  = '{2'b00, 20'h00401, 10'h100, 10'd1,    100, 100, 3, 0,  -1, 7};
        vecs[2]  = '{2'b01, 20'h00C03, 10'h010, 10'd7,    100, 100, 0, 20, -1, -1};
        vecs[3]  = '{2'b10, 20'h00000, 10'h000, 10'd1023, 100, 100, 0, 0,  'h2AAAA, 1026};
        vecs[4]  = '{2'b01, 20'h00005, 10'h000, 10'd3,    100, 100, 0, 0,  -1, -1};
        vecs[5]  = '{2'b11, 20'h00401, 10'h000, 10'd3,    100, 100, 0, 0,  -1, -1};
        vecs[6]  = '{2'b01, 20'h00400, 10'h020, 10'd0,    100, 100, 0, 0,  -1, -1};
        vecs[7]  = '{2'b00, 20'hFFFFF, 10'h005, 10'd0,    100, 100, 0, 0,  -1, 3};
        vecs[8]  = '{2'b10, 20'h12345, 10'h3F0, 10'd31,   30,  100, 0, 0,  -1, -1};
        vecs[9]  = '{2'b01, 20'h00401, 10'h3FD, 10'd5,    100, 100, 0, 0,  -1, -1};
        vecs[10] = '{2'b01, 20'h0F00F, 10'h3FA, 10'd12,   100, 30,  0, 0,  -1, -1};

        // Reset values while reset is held.
        repeat (3) step();
        chk("rst_pl", {PL_ENA_o, PL_INIT_o, PL_WEN_o, PL_REN_o, |PL_ADDR_o, |PL_DATA_o}, 0);
        chk("rst_status", {BUSY_o, DONE_o, ERR_o, RD_VALID_o, CMD_READY_o, WD_READY_o}, 0);
        RESET_ni = 1'b1;
        step();
        chk("ready_after_reset", CMD_READY_o, 1);

        foreach (vecs[i])
            run_cmd(vecs[i].op, vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].wd_pct,
                    vecs[i].rd_pct, vecs[i].gap, vecs[i].hold, vecs[i].fw, vecs[i].exp_ena);

        for (int i = 0; i < 16; i++)
            run_cmd(2'($urandom_range(3)), 20'($urandom), 10'($urandom), 10'($urandom_range(40)),
                    int'($urandom_range(30, 100)), int'($urandom_range(20, 100)), 0, 0, -1, -1);

        // Reset in the middle of a streaming read.
        mon_clear();
        CMD_VALID_i = 1'b1; CMD_OP_i = 2'b01; CMD_ID_i = 20'h00801;
        CMD_ADDR_i = 10'h000; CMD_LEN_i = 10'd20;
        step();
        CMD_VALID_i = 1'b0;
        RD_READY_i  = 1'b1;
        cyc = 0;
        while (rq_a.size() < 3 && cyc < 50) begin step(); cyc++; end
        chk("rst_read_started", longint'(cyc >= 50), 0);
        RESET_ni = 1'b0;
        step();
        chk("midrst_pl", {PL_ENA_o, PL_INIT_o, PL_WEN_o, PL_REN_o, |PL_ADDR_o, |PL_DATA_o}, 0);
        chk("midrst_status", {BUSY_o, DONE_o, RD_VALID_o, CMD_READY_o}, 0);
        step();
        RESET_ni = 1'b1;
        seen = 0;
        repeat (10) begin
            step();
            if (RD_VALID_o || PL_ENA_o) seen++;
        end
        RD_READY_i = 1'b0;
        chk("midrst_no_activity", seen, 0);
        chk("midrst_no_done", done_cnt, 0);
        run_cmd(2'b00, 20'h00C07, 10'h123, 10'd9, 100, 100, 0, 0, -1, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
